// File: rtl/muldiv_if.sv
// Request/result bundle between the control unit and the iterative multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, div_zero, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/DIV unit: magnitude shift-add / restoring divide, sign fix-up in a final cycle.
// Optional MULDIV_UNSIGNED_EN enables op[1] as the unsigned (multu/divu) select.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input logic  clk,
  input logic  reset,
  muldiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state, stateNext;
  logic               accept;
  logic               isDivR, negLoR, negHiR;
  logic [WIDTH-1:0]   dvsR;
  logic [2*WIDTH-1:0] accR;
  logic [CNT_W-1:0]   cnt;

  logic               opSigned, opDiv, aNeg, bNeg, divByZero;
  logic [WIDTH-1:0]   aMag, bMag;

  assign opDiv = bus.op[0];
`ifdef MULDIV_UNSIGNED_EN
  assign opSigned = ~bus.op[1];
`else
  logic unusedOpHi;
  assign opSigned   = 1'b1;
  assign unusedOpHi = bus.op[1];
`endif
  assign aNeg      = opSigned & bus.a[WIDTH-1];
  assign bNeg      = opSigned & bus.b[WIDTH-1];
  assign aMag      = aNeg ? -bus.a : bus.a;
  assign bMag      = bNeg ? -bus.b : bus.b;
  assign divByZero = opDiv && (bus.b == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        stateNext = IDLE;
        if (bus.start) begin
          accept    = 1'b1;
          stateNext = divByZero ? DONE : CALC;
        end
      end
      CALC:    if (cnt == CNT_W'(WIDTH-1)) stateNext = FIX;
      FIX:     stateNext = DONE;
      default: stateNext = IDLE;
    endcase
  end

  // Low half of accR holds the multiplier (shifted out) or the quotient (shifted in).
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divShift;
  logic               divGe;
  logic [WIDTH-1:0]   divRem;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix, remFix;

  assign mulSum   = {1'b0, accR[2*WIDTH-1:WIDTH]} + {1'b0, (accR[0] ? dvsR : '0)};
  assign divShift = {accR[2*WIDTH-1:WIDTH], accR[WIDTH-1]};
  assign divGe    = divShift >= {1'b0, dvsR};
  assign divRem   = divShift[WIDTH-1:0] - dvsR;
  assign prodFix  = negLoR ? -accR : accR;
  assign quoFix   = negLoR ? -accR[WIDTH-1:0] : accR[WIDTH-1:0];
  assign remFix   = negHiR ? -accR[2*WIDTH-1:WIDTH] : accR[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accR   <= '0;
      dvsR   <= '0;
      cnt    <= '0;
      isDivR <= 1'b0;
      negLoR <= 1'b0;
      negHiR <= 1'b0;
      bus.hi <= '0;
      bus.lo <= '0;
    end else if (accept) begin
      accR   <= {{WIDTH{1'b0}}, aMag};
      dvsR   <= bMag;
      cnt    <= '0;
      isDivR <= opDiv;
      negLoR <= aNeg ^ bNeg;
      negHiR <= aNeg;
    end else if (state == CALC) begin
      cnt <= cnt + CNT_W'(1);
      if (isDivR)
        accR <= divGe ? {divRem, accR[WIDTH-2:0], 1'b1}
                      : {divShift[WIDTH-1:0], accR[WIDTH-2:0], 1'b0};
      else
        accR <= {mulSum, accR[WIDTH-1:1]};
    end else if (state == FIX) begin
      if (isDivR) {bus.hi, bus.lo} <= {remFix, quoFix};
      else        {bus.hi, bus.lo} <= prodFix;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
    end else begin
      bus.busy     <= (stateNext == CALC) || (stateNext == FIX);
      bus.done     <= (stateNext == DONE);
      bus.div_zero <= accept && divByZero;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a 32-bit instance tracked cycle by cycle against an
// arithmetic model, plus an 8-bit instance checked against literal results.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus  ();
  muldiv_if #(.WIDTH(8))  bus8 ();

  muldiv_unit #(.WIDTH(32)) dut  (.clk(clk), .reset(rst), .bus(bus.slave));
  muldiv_unit #(.WIDTH(8))  dut8 (.clk(clk), .reset(rst), .bus(bus8.slave));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected result straight from the arithmetic definition of each op.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output bit dz);
    bit          uns;
    logic [63:0] p;
    longint      sa, sb, q, r;
`ifdef MULDIV_UNSIGNED_EN
    uns = op[1];
`else
    uns = 1'b0;
`endif
    dz = op[0] && (b == 32'd0);
    h  = '0;
    l  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!op[0]) begin
      if (uns) p = {32'd0, a} * {32'd0, b};
      else     p = sa * sb;
      {h, l} = p;
    end else if (!dz) begin
      if (uns) begin
        l = a / b;
        h = a % b;
      end else begin
        q = sa / sb;
        r = sa % sb;
        l = q[31:0];
        h = r[31:0];
      end
    end
  endfunction

  // Transaction-level model: one op in flight, completes WIDTH+1 edges after acceptance.
  longint      edgeCnt = 0, doneEdge = 0;
  bit          pend = 0, expDone = 0, expDz = 0;
  logic [31:0] curHi = '0, curLo = '0, nxtHi = '0, nxtLo = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend = 0; expDone = 0; expDz = 0;
      curHi = '0; curLo = '0;
    end else begin
      bit          acc, dz;
      logic [31:0] h, l;
      edgeCnt++;
      expDone = 0;
      expDz   = 0;
      acc     = bus.start && !pend;
      if (pend && edgeCnt == doneEdge) begin
        expDone = 1;
        curHi   = nxtHi;
        curLo   = nxtLo;
        pend    = 0;
      end
      if (acc) begin
        model(bus.op, bus.a, bus.b, h, l, dz);
        if (dz) begin
          expDone = 1;
          expDz   = 1;
        end else begin
          nxtHi    = h;
          nxtLo    = l;
          pend     = 1;
          doneEdge = edgeCnt + 33;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("mon_done", 64'(bus.done), 64'(expDone));
    chk("mon_busy", 64'(bus.busy), 64'(pend));
    chk("mon_divzero", 64'(bus.div_zero), 64'(expDz));
    chk("mon_hi", 64'(bus.hi), 64'(curHi));
    chk("mon_lo", 64'(bus.lo), 64'(curLo));
  end

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
  endtask

  // Pulse start for one edge; returns at the negedge after the start edge.
  task automatic startOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    drive(op, a, b);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input string name, output int n);
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) chk({name, "_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic runOp8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, output int lat);
    int n;
    @(negedge clk);
    bus8.start = 1'b1; bus8.op = op; bus8.a = a; bus8.b = b;
    @(negedge clk);
    bus8.start = 1'b0;
    n = 0;
    while (!bus8.done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus8.done) chk("w8_timeout", 64'(0), 64'(1));
    lat = n + 1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    bus8.start = 1'b0; bus8.op = '0; bus8.a = '0; bus8.b = '0;
    #12;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_hi", 64'(bus.hi), 64'(0));
    chk("rst_lo", 64'(bus.lo), 64'(0));
    @(negedge clk); #2 rst = 1'b0;

    // 7 * -3
    startOp(2'b00, 32'd7, 32'hFFFF_FFFD);
    chk("mult_busy", 64'(bus.busy), 64'(1));
    waitDone("mult", n);
    chk("mult_latency", 64'(n + 1), 64'(34));
    chk("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(bus.lo), 64'hFFFF_FFEB);

    // -7 / 2
    startOp(2'b01, 32'hFFFF_FFF9, 32'd2);
    waitDone("div", n);
    chk("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);

    // most-negative / -1 wraps
    startOp(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone("ovf", n);
    chk("ovf_lo", 64'(bus.lo), 64'h8000_0000);
    chk("ovf_hi", 64'(bus.hi), 64'h0);
    chk("ovf_dz", 64'(bus.div_zero), 64'(0));

    // divide by zero leaves hi/lo alone
    startOp(2'b01, 32'd123, 32'd0);
    waitDone("dz", n);
    chk("dz_latency", 64'(n + 1), 64'(1));
    chk("dz_flag", 64'(bus.div_zero), 64'(1));
    chk("dz_hi", 64'(bus.hi), 64'h0);
    chk("dz_lo", 64'(bus.lo), 64'h8000_0000);

    // start during CALC is ignored
    startOp(2'b00, 32'd5, 32'd6);
    repeat (5) @(negedge clk);
    drive(2'b00, 32'd9, 32'd9);
    @(negedge clk);
    bus.start = 1'b0;
    waitDone("ign", n);
    chk("ign_lo", 64'(bus.lo), 64'd30);
    chk("ign_hi", 64'(bus.hi), 64'd0);

    // start held through DONE: back-to-back ops
    @(negedge clk);
    drive(2'b00, 32'd3, 32'd4);
    @(negedge clk);
    waitDone("b2b1", n);
    chk("b2b1_lo", 64'(bus.lo), 64'd12);
    drive(2'b01, 32'd100, 32'd7);
    @(negedge clk);
    bus.start = 1'b0;
    waitDone("b2b2", n);
    chk("b2b2_latency", 64'(n + 1), 64'(34));
    chk("b2b2_lo", 64'(bus.lo), 64'd14);
    chk("b2b2_hi", 64'(bus.hi), 64'd2);

    // reset mid-CALC aborts the op
    startOp(2'b00, 32'd11, 32'd13);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'(0));
    chk("arst_done", 64'(bus.done), 64'(0));
    chk("arst_dz", 64'(bus.div_zero), 64'(0));
    chk("arst_hi", 64'(bus.hi), 64'(0));
    chk("arst_lo", 64'(bus.lo), 64'(0));
    @(negedge clk); #2 rst = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) n++;
    end
    chk("arst_nodone", 64'(n), 64'(0));
    startOp(2'b00, 32'd11, 32'd13);
    waitDone("post_rst", n);
    chk("post_rst_lo", 64'(bus.lo), 64'd143);

    // op[1] set: unsigned only when the option is compiled in
    startOp(2'b10, 32'hFFFF_FFFF, 32'd2);
    waitDone("cfg", n);
`ifdef MULDIV_UNSIGNED_EN
    chk("cfg_hi", 64'(bus.hi), 64'h1);
`else
    chk("cfg_hi", 64'(bus.hi), 64'hFFFF_FFFF);
`endif
    chk("cfg_lo", 64'(bus.lo), 64'hFFFF_FFFE);
    startOp(2'b11, 32'hFFFF_FFF0, 32'd3);
    waitDone("cfg_div", n);
    @(negedge clk);

    // narrow build
    runOp8(2'b01, 8'd100, 8'd7, n);
    chk("w8_div_latency", 64'(n), 64'(10));
    chk("w8_div_lo", 64'(bus8.lo), 64'd14);
    chk("w8_div_hi", 64'(bus8.hi), 64'd2);
    runOp8(2'b00, 8'h80, 8'h80, n);
    chk("w8_mult_hi", 64'(bus8.hi), 64'h40);
    chk("w8_mult_lo", 64'(bus8.lo), 64'h00);
    runOp8(2'b01, 8'h80, 8'hFF, n);
    chk("w8_ovf_lo", 64'(bus8.lo), 64'h80);
    chk("w8_ovf_hi", 64'(bus8.hi), 64'h00);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
